// File: rtl/store_buffer.sv
// Store buffer: aligns MEM-stage stores onto bus lanes, checks natural
// alignment, queues accepted stores in a small FIFO and drains them to memory
// over a req/ack handshake. Also flags loads that hit a pending store word.
module store_buffer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  input  logic [1:0]                 st_size,
  output logic                       st_ready,
  output logic                       st_exc,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  output logic [DW/8-1:0]            mem_byteen,
  input  logic                       mem_ack,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [NB-1:0] be_q   [DEPTH];
  logic [NB-1:0] be_d   [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [OB-1:0] off;
  logic [OB-1:0] off_mask;
  logic [NB-1:0] lane_en;
  logic [DW-1:0] data_m;
  logic [NB-1:0] st_byteen;
  logic [DW-1:0] st_wdata;
  logic [AW-1:0] st_word;
  logic [AW-1:0] ld_word;
  logic          push, pop;

  assign off     = st_addr[OB-1:0];
  assign st_word = {st_addr[AW-1:OB], {OB{1'b0}}};
  assign ld_word = {ld_addr[AW-1:OB], {OB{1'b0}}};

  // Store formatting: exception check, byte enables, lane-aligned data.
  always_comb begin
    off_mask = '0;
    lane_en  = '0;
    data_m   = '0;
    for (int unsigned j = 0; j < OB; j++) begin
      off_mask[j] = (j < 32'(st_size));
    end
    for (int unsigned b = 0; b < NB; b++) begin
      lane_en[b]       = (b < (32'd1 << st_size));
      data_m[b*8 +: 8] = lane_en[b] ? st_data[b*8 +: 8] : 8'h00;
    end
    st_byteen = lane_en << off;
    st_wdata  = data_m << {off, 3'b000};
    st_exc    = st_valid && ((32'(st_size) > OB) || ((off & off_mask) != '0));
  end

  assign st_ready = (count_q < CW'(DEPTH));
  assign mem_req  = (count_q != '0);
  assign push     = st_valid && st_ready && !st_exc;
  assign pop      = mem_req && mem_ack;

  assign mem_addr   = addr_q[head_q];
  assign mem_wdata  = data_q[head_q];
  assign mem_byteen = be_q[head_q];
  assign count      = count_q;

  // Next-state for pointers, occupancy and the entry written at the tail.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      addr_d[tail_q] = st_word;
      data_d[tail_q] = st_wdata;
      be_d[tail_q]   = st_byteen;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
  end

  // Load hit: only registered, occupied entries; an entry popping this
  // cycle is still occupied and therefore still hits.
  always_comb begin
    logic [PW-1:0] rel;
    ld_hit = 1'b0;
    rel    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - head_q;
      if (({1'b0, rel} < count_q) && (addr_q[i] == ld_word)) begin
        ld_hit = ld_valid;
      end
    end
  end

  // Control state with synchronous reset; entry payload needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DW=32, DEPTH=4) with a scoreboard queue
// holding the expected drained entries in issue order.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        st_exc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } entry_t;

  entry_t sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;

  store_buffer #(.DW(32), .AW(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .st_ready   (st_ready),
    .st_exc     (st_exc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_ack    (mem_ack),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .count      (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] sz);
    entry_t e;
    int unsigned n, off;
    logic [31:0] mask;
    n    = 1 << sz;
    off  = a[1:0];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    e.a  = a & ~32'h3;
    e.be = 4'(((1 << n) - 1) << off);
    e.d  = (d & mask) << (8 * off);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock: drive a store/ack, check combinational outputs and the head
  // against the scoreboard, update the model, then advance past the edge.
  task automatic cycle(input bit sv, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit ack);
    bit exp_exc, push, pop;
    entry_t e;
    st_valid = sv; st_addr = a; st_data = d; st_size = sz; mem_ack = ack;
    #2;
    exp_exc = sv && (sz == 2'd3 || (a & ((32'd1 << sz) - 32'd1)) != 0);
    chk("st_exc", st_exc, exp_exc);
    chk("st_ready", st_ready, sb.size() < 4);
    chk("count", count, sb.size());
    chk("mem_req", mem_req, sb.size() != 0);
    if (sb.size() != 0) begin
      e = sb[0];
      chk("mem_addr", mem_addr, e.a);
      chk("mem_wdata", mem_wdata, e.d);
      chk("mem_byteen", mem_byteen, e.be);
    end
    push = sv && !exp_exc && (sb.size() < 4);
    pop  = ack && (sb.size() != 0);
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back(model(a, d, sz));
    step();
    st_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic idle(input bit ack);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, ack);
  endtask

  task automatic drain_all();
    while (sb.size() != 0) idle(1'b1);
  endtask

  task automatic ld_check(input string tag, input logic [31:0] a, input bit exp_hit);
    ld_valid = 1'b1; ld_addr = a;
    #2;
    chk(tag, ld_hit, exp_hit);
    ld_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    mem_ack = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    idle(1'b0);
    ld_check("ld_hit_reset", 32'h0, 1'b0);

    // sb at 0x1003
    cycle(1'b1, 32'h1003, 32'h0000_00AB, 2'd0, 1'b0);
    #2;
    chk("sb_req", mem_req, 1'b1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", mem_byteen, 4'b1000);
    chk("sb_data", mem_wdata, 32'hAB00_0000);
    chk("sb_cnt1", count, 3'd1);
    idle(1'b1);
    chk("sb_cnt0", count, 3'd0);

    // sh aligned, sh misaligned, sw misaligned
    cycle(1'b1, 32'h2002, 32'hFFFF_1234, 2'd1, 1'b0);
    #2;
    chk("sh_be", mem_byteen, 4'b1100);
    chk("sh_data", mem_wdata, 32'h1234_0000);
    cycle(1'b1, 32'h2001, 32'h5555_5555, 2'd1, 1'b0);
    cycle(1'b1, 32'h2006, 32'h6666_6666, 2'd2, 1'b0);
    cycle(1'b1, 32'h2000, 32'h7777_7777, 2'd3, 1'b0);
    chk("exc_cnt", count, 3'd1);
    drain_all();

    // Fill to full, fifth held off, then drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2, 1'b0);
    cycle(1'b1, 32'h20, 32'hDEAD_BEEF, 2'd2, 1'b0);
    chk("full_cnt", count, 3'd4);
    // Full with ack in the same cycle: no bypass
    cycle(1'b1, 32'h24, 32'hBAD0_BAD0, 2'd2, 1'b1);
    chk("after_pop_ready", st_ready, 1'b1);
    drain_all();

    // Concurrent push/pop at count=2 across pointer wrap
    cycle(1'b1, 32'h100, 32'h1, 2'd2, 1'b0);
    cycle(1'b1, 32'h104, 32'h2, 2'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'($urandom_range(0, 255)),
            2'(i % 3), 1'b1);
      chk("wrap_cnt", count, 3'd2);
    end
    drain_all();

    // Load hit
    cycle(1'b1, 32'h3000, 32'hCAFE_F00D, 2'd2, 1'b0);
    ld_check("ld_hit_same_word", 32'h3002, 1'b1);
    ld_check("ld_hit_other_word", 32'h3004, 1'b0);
    drain_all();
    ld_check("ld_hit_drained", 32'h3002, 1'b0);

    // Reset mid-drain with ack asserted
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 32'h9 + 32'(i), 2'd2, 1'b0);
    reset = 1'b1; mem_ack = 1'b1;
    step();
    reset = 1'b0; mem_ack = 1'b0;
    sb.delete();
    #2;
    chk("rst_cnt", count, 3'd0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_ready", st_ready, 1'b1);
    idle(1'b1);
    idle(1'b0);
    cycle(1'b1, 32'h500, 32'h1234_5678, 2'd2, 1'b0);
    drain_all();
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
